// File: rtl/layer_output_serializer.sv
// -----------------------------------------------------------------------------
// layer_output_serializer
//
// Captures the parallel outputs of one neural-network layer on its common
// outvalid strobe and replays them as a serial stream, one word per beat, in
// neuron-index order. The stream feeds the next layer's shared
// myinput/myinputValid broadcast.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active-low
//   in_data    : numNeuron*dataWidth neuron outputs, neuron i at
//                [i*dataWidth +: dataWidth]
//   in_valid   : one-cycle capture strobe (layer outvalid)
//   out_data   : current word of the replayed frame
//   out_valid  : out_data is valid
//   out_ready  : consumer accepts the current word
//   busy       : a frame is being replayed
//   frame_done : one-cycle pulse after the last word of a frame is accepted
//   overrun    : sticky flag, a frame arrived while busy and was dropped
//
// All outputs come from registers. No combinational path from in_* to out_*.
// -----------------------------------------------------------------------------
module layer_output_serializer #(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numNeuron*dataWidth-1:0] in_data,
    input  logic                           in_valid,
    output logic [dataWidth-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);

    localparam int CW = (numNeuron < 2) ? 1 : $clog2(numNeuron);
    localparam logic [CW-1:0] LAST_IDX = CW'(numNeuron - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_n;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_n;
    logic [dataWidth-1:0] buffer_r [numNeuron];
    logic [dataWidth-1:0] out_data_r;
    logic [dataWidth-1:0] out_data_n;
    logic                 frame_done_r;
    logic                 frame_done_n;
    logic                 overrun_r;
    logic                 overrun_n;
    logic                 load_s;
    logic                 beat_s;

    // Next-state and next-output decode for the replay FSM.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        out_data_n   = out_data_r;
        frame_done_n = 1'b0;
        overrun_n    = overrun_r;
        load_s       = 1'b0;
        beat_s       = (state_r == SEND) && out_ready;

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    // Word 0 is presented straight from in_data so that the
                    // first word is visible one cycle after capture.
                    load_s     = 1'b1;
                    cnt_n      = {CW{1'b0}};
                    out_data_n = in_data[dataWidth-1:0];
                    state_n    = SEND;
                end else begin
                    state_n = IDLE;
                end
            end

            SEND: begin
                if (beat_s && (cnt_r == LAST_IDX)) begin
                    frame_done_n = 1'b1;
                    cnt_n        = {CW{1'b0}};
                    if (in_valid) begin
                        // Last word leaves while a new frame arrives: chain
                        // the frames without a bubble; this is not an overrun.
                        load_s     = 1'b1;
                        out_data_n = in_data[dataWidth-1:0];
                        state_n    = SEND;
                    end else begin
                        out_data_n = {dataWidth{1'b0}};
                        state_n    = IDLE;
                    end
                end else begin
                    if (in_valid) begin
                        overrun_n = 1'b1;
                    end else begin
                        overrun_n = overrun_r;
                    end
                    if (beat_s) begin
                        cnt_n      = cnt_r + CW'(1);
                        out_data_n = buffer_r[cnt_r + CW'(1)];
                    end else begin
                        cnt_n      = cnt_r;
                        out_data_n = out_data_r;
                    end
                end
            end

            default: begin
                state_n    = IDLE;
                cnt_n      = {CW{1'b0}};
                out_data_n = {dataWidth{1'b0}};
            end
        endcase
    end

    // FSM state, index counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            out_data_r   <= {dataWidth{1'b0}};
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            out_data_r   <= out_data_n;
            frame_done_r <= frame_done_n;
            overrun_r    <= overrun_n;
        end
    end

    // Frame buffer, loaded only when a frame is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < numNeuron; i++) begin
                buffer_r[i] <= {dataWidth{1'b0}};
            end
        end else if (load_s) begin
            for (int i = 0; i < numNeuron; i++) begin
                buffer_r[i] <= in_data[i*dataWidth +: dataWidth];
            end
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = (state_r == SEND);
    assign busy       = (state_r == SEND);
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_layer_output_serializer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for layer_output_serializer (numNeuron=4, dataWidth=16).
// The driver keeps a frame-level reference model (words still owed for the
// current frame, sticky overrun) and pushes every expected word into a
// scoreboard queue; a monitor pops and compares on each accepted beat.
// -----------------------------------------------------------------------------
module tb_layer_output_serializer;

    localparam int NN = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [NN*DW-1:0] in_data;
    logic             in_valid;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             frame_done;
    logic             overrun;

    int               checks;
    int               errors;
    exp_t             exp_q[$];
    int               rem;
    logic             exp_ovr;
    logic [NN*DW-1:0] cur_frame;

    layer_output_serializer #(.numNeuron(NN), .dataWidth(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input logic [NN*DW-1:0] d, input int i);
        return d[i*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat; checks frame_done
    // against whether the previous beat carried the last word of a frame.
    initial begin
        exp_t e;
        logic prev_last;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_last = 1'b0;
            end else begin
                check("frame_done", {63'd0, frame_done}, {63'd0, prev_last});
                prev_last = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {48'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", {48'd0, out_data}, {48'd0, e.data});
                        prev_last = e.last;
                    end
                end
            end
        end
    end

    // One clock of stimulus; the model predicts the effect of the coming edge.
    task automatic drive_cycle(input logic iv, input logic [NN*DW-1:0] d, input logic rdy);
        logic beat;
        logic last;
        exp_t e;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        beat = (rem > 0) && rdy;
        last = beat && (rem == 1);
        if (iv && ((rem == 0) || last)) begin
            for (int i = 0; i < NN; i++) begin
                e.data = word_of(d, i);
                e.last = (i == NN - 1);
                exp_q.push_back(e);
            end
            cur_frame = d;
            rem = NN;
        end else begin
            if (iv) exp_ovr = 1'b1;
            if (beat) rem = rem - 1;
        end
        @(posedge clk);
        #1;
        check("busy", {63'd0, busy}, {63'd0, (rem > 0)});
        check("out_valid", {63'd0, out_valid}, {63'd0, (rem > 0)});
        check("overrun", {63'd0, overrun}, {63'd0, exp_ovr});
        if (rem > 0) begin
            check("out_data_shown", {48'd0, out_data}, {48'd0, word_of(cur_frame, NN - rem)});
        end
    endtask

    // Holds reset for a few cycles; outputs must drop at once and stay zero.
    task automatic apply_reset(input int cycles, input bit toggle);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        rem = 0;
        exp_ovr = 1'b0;
        #1;
        check("rst_async_valid", {63'd0, out_valid}, 64'd0);
        check("rst_async_busy", {63'd0, busy}, 64'd0);
        for (int c = 0; c < cycles; c++) begin
            if (toggle) begin
                in_valid = ~in_valid;
                in_data  = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_frame_done", {63'd0, frame_done}, 64'd0);
            check("rst_overrun", {63'd0, overrun}, 64'd0);
            check("rst_out_data", {48'd0, out_data}, 64'd0);
        end
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NN*DW-1:0] f1;
        logic [NN*DW-1:0] f2;
        logic [NN*DW-1:0] fa;
        int budget;
        f1 = 64'h0004_0003_0002_0001;
        f2 = 64'h0008_0007_0006_0005;
        fa = 64'hAAAA_AAAA_AAAA_AAAA;
        checks = 0;
        errors = 0;
        rem = 0;
        exp_ovr = 1'b0;
        cur_frame = '0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset with in_valid toggling
        apply_reset(3, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);

        // Single frame, always ready
        drive_cycle(1'b1, f1, 1'b1);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1);

        // Backpressure while 0002 is shown
        drive_cycle(1'b1, f1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b0, '0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, '0, 1'b1);

        // Back-to-back: new frame on the cycle the last word is accepted
        drive_cycle(1'b1, f1, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b1, f2, 1'b1);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1);

        // Overrun: frame arrives during beat 2 and is dropped
        drive_cycle(1'b1, f1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b1, fa, 1'b1);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1);

        // Mid-frame reset while 0002 is shown, then stay idle
        drive_cycle(1'b1, f1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        apply_reset(2, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 7) == 0), {$urandom, $urandom},
                        ($urandom_range(0, 3) != 0));
        end

        // Drain
        budget = 0;
        while ((exp_q.size() > 0) && (budget < 100)) begin
            drive_cycle(1'b0, '0, 1'b1);
            budget++;
        end
        drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        check("scoreboard_empty", exp_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
